// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle logical left shifter.
//   A request (start with Signal == SLL_CODE) is accepted only in IDLE. The
//   operand is then shifted one bit per cycle, or four bits per cycle while at
//   least four remain when SHIFTER_FAST_EN is defined. The result is written
//   to dataOut and announced with a one-cycle done pulse.
// Optional feature macro: SHIFTER_FAST_EN (4-bit steps while cnt >= 4).
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high reset
//   start   - request pulse, sampled only in IDLE
//   dataA   - operand to shift
//   dataB   - shift amount, only dataB[4:0] is used
//   Signal  - function code, must equal SLL_CODE for a request to be accepted
//   dataOut - last completed result
//   busy    - high while the FSM is not in IDLE
//   done    - one-cycle completion pulse, dataOut is valid while it is high
module shift_left_seq #(
  parameter logic [5:0] SLL_CODE = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] IDLE  = 2'd0;
  localparam logic [SW-1:0] SHIFT = 2'd1;
  localparam logic [SW-1:0] DONE  = 2'd2;

  logic [SW-1:0] state, state_d;
  logic [DW-1:0] work, work_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [DW-1:0] dout_d;
  logic          busy_d;
  logic          done_d;

  // Upper shift-amount bits carry no meaning for a 32-bit shift.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^dataB[31:5];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      dataOut <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      work    <= work_d;
      cnt     <= cnt_d;
      dataOut <= dout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state;
    work_d  = work;
    cnt_d   = cnt;
    dout_d  = dataOut;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start && (Signal == SLL_CODE)) begin
          state_d = SHIFT;
          work_d  = dataA;
          cnt_d   = dataB[CW-1:0];
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          dout_d  = work;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
`ifdef SHIFTER_FAST_EN
          if (cnt >= CW'(4)) begin
            work_d = {work[DW-5:0], 4'b0000};
            cnt_d  = cnt - CW'(4);
          end else begin
            work_d = {work[DW-2:0], 1'b0};
            cnt_d  = cnt - CW'(1);
          end
`else
          work_d = {work[DW-2:0], 1'b0};
          cnt_d  = cnt - CW'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard testbench for shift_left_seq: stimulus pushes the expected result
// and the cycle at which done must appear; a monitor pops on every done pulse.
module tb_shift_left_seq;

  localparam logic [5:0] SLL = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = 32'h0;

  shift_left_seq #(.SLL_CODE(SLL)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges from the start-sampling edge (inclusive) to the edge raising done.
  function automatic int lat(input logic [4:0] s);
`ifdef SHIFTER_FAST_EN
    return int'(s >> 2) + int'(s & 5'd3) + 2;
`else
    return int'(s) + 2;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (prev_done === 1'b1) begin
        errors++;
        $display("FAIL done_width: done high on consecutive cycles at cyc %0d", cyc);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: dataOut=%h at cyc %0d, none expected", dataOut, cyc);
      end else begin
        e = q.pop_front();
        checks += 2;
        if (dataOut !== e.data) begin
          errors++;
          $display("FAIL result: dataOut=%h expected %h", dataOut, e.data);
        end
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: done at cyc %0d expected cyc %0d", cyc, e.due);
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input bit interfere);
    exp_t e;
    dataA  = a;
    dataB  = b;
    Signal = SLL;
    start  = 1'b1;
    e.data = exp_d;
    e.due  = cyc + lat(b[4:0]);
    q.push_back(e);
    last_res = exp_d;
    @(negedge clk);
    start  = 1'b0;
    dataA  = ~a;
    dataB  = b ^ 32'h0000_001F;
    Signal = 6'h2A;
    if (interfere) begin
      start  = 1'b1;
      dataA  = 32'h5555_5555;
      dataB  = 32'h1;
      Signal = SLL;
      @(negedge clk);
      start  = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    dataA  = 32'h0;
    dataB  = 32'h0;
    Signal = SLL;
    repeat (3) @(negedge clk);
    chk("reset_dataOut", dataOut, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(32'h0000_000F, 32'hFFFF_FFE3, 32'h0000_0078, 1'b1);
    run_op(32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0005, 32'h0000_0060, 1'b0);

    // Abort a shamt=10 operation with reset on its third SHIFT edge.
    dataA  = 32'h1234_5678;
    dataB  = 32'h0000_000A;
    Signal = SLL;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_running", {31'h0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res = 32'h0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_dataOut", dataOut, 32'h0);
    repeat (14) @(negedge clk);
    chk("abort_no_late_done_dataOut", dataOut, 32'h0);

    run_op(32'h1234_5678, 32'h0000_000A, 32'hD159_E000, 1'b0);

    // Wrong function code must be ignored.
    dataA  = 32'hCAFE_F00D;
    dataB  = 32'h0000_0002;
    Signal = 6'b000010;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("badsig_busy", {31'h0, busy}, 32'h0);
    repeat (4) @(negedge clk);
    chk("badsig_busy_later", {31'h0, busy}, 32'h0);
    chk("badsig_dataOut", dataOut, last_res);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 Parameter SLL_CODE, default 6'b000000: function code on Signal that selects a logical left shift.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dataA  input  32  operand to be shifted.
REQ-006 dataB  input  32  shift amount; only dataB[4:0] is used, dataB[31:5] is ignored.
REQ-007 Signal  input  6  function code; a request is accepted only when Signal equals SLL_CODE.
REQ-008 dataOut  output  32  result register; holds the last completed result.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse; dataOut is valid while done is high.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE -> SHIFT SHALL occur on a rising edge with start=1 and Signal=SLL_CODE; on that edge the block SHALL capture dataA into the work register and dataB[4:0] into a 5-bit counter cnt.
REQ-013 In IDLE, start with Signal!=SLL_CODE SHALL be ignored: state stays IDLE, no done pulse, dataOut unchanged.
REQ-014 In SHIFT with cnt!=0, each edge SHALL set work<=work<<1 (zero fill at bit 0, bit 31 discarded) and cnt<=cnt-1.
REQ-015 In SHIFT with cnt==0, the edge SHALL load dataOut<=work and move to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE.
REQ-017 Latency SHALL be shamt+2 edges from the start-sampling edge to the edge after which done is high (shamt=dataB[4:0]); shamt=0 gives 2.
REQ-018 start SHALL be ignored while busy=1; in-flight operands SHALL be unaffected.
REQ-019 Changes to dataA, dataB or Signal after acceptance SHALL NOT affect the result.
REQ-020 dataOut SHALL change only on the SHIFT->DONE edge or on reset.
REQ-021 A new start in the cycle immediately after DONE (state IDLE) SHALL be accepted normally.

Reset
REQ-022 On any edge with reset=1, the FSM SHALL go to IDLE and set dataOut=0, done=0, busy=0, cnt=0 and work=0.
REQ-023 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.

Configuration
REQ-024 Macro SHIFTER_FAST_EN: when it is defined, each SHIFT edge with cnt>=4 SHALL shift by 4 and subtract 4, and each SHIFT edge with 1<=cnt<=3 SHALL shift by 1.
REQ-025 With SHIFTER_FAST_EN defined, latency SHALL be floor(shamt/4)+(shamt mod 4)+2 edges.
REQ-026 With SHIFTER_FAST_EN undefined, behaviour SHALL be exactly REQ-014 and REQ-017.
REQ-027 Results SHALL be identical in both configurations.

Verification
REQ-028 dataA=0x00000001, dataB=4, Signal=0, start -> done after 6 edges (fast: 3), dataOut=0x00000010.
REQ-029 dataA=0xDEADBEEF, dataB=0 -> done after 2 edges, dataOut=0xDEADBEEF.
REQ-030 dataA=0xFFFFFFFF, dataB=0xFFFFFFFF (shamt 31) -> dataOut=0x80000000, latency 33 (fast: 12).
REQ-031 Accepted request dataA=0x0000000F, dataB=0xFFFFFFE3 (shamt 3), then a second start with different operands while busy -> dataOut=0x00000078, exactly one done pulse.
REQ-032 reset=1 on the third SHIFT edge of a shamt=10 operation -> busy=0, done=0, dataOut=0, no done pulse; the next request completes correctly.
REQ-033 start with Signal=6'b000010 -> busy stays 0, no done pulse, dataOut unchanged.
